// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Owner encoding also serves as the round-robin history value.
package kianv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned WAIT_CNT_W       = 16;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and downstream memory.
// slave is the arbiter's view; master is the requester/memory environment.
interface cache_mem_arbiter_if;

    logic [31:0] i_addr_i;
    logic        i_valid_i;
    logic [31:0] i_dout_o;
    logic        i_ready_o;

    logic [31:0] d_addr_i;
    logic [31:0] d_din_i;
    logic [3:0]  d_wmask_i;
    logic        d_valid_i;
    logic [31:0] d_dout_o;
    logic        d_ready_o;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_din_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_valid_o;
    logic [31:0] mem_dout_i;
    logic        mem_ready_i;

    logic        err_o;

    modport slave (
        input  i_addr_i, i_valid_i,
        input  d_addr_i, d_din_i, d_wmask_i, d_valid_i,
        input  mem_dout_i, mem_ready_i,
        output i_dout_o, i_ready_o,
        output d_dout_o, d_ready_o,
        output mem_addr_o, mem_din_o, mem_wmask_o, mem_valid_o,
        output err_o
    );

    modport master (
        output i_addr_i, i_valid_i,
        output d_addr_i, d_din_i, d_wmask_i, d_valid_i,
        output mem_dout_i, mem_ready_i,
        input  i_dout_o, i_ready_o,
        input  d_dout_o, d_ready_o,
        input  mem_addr_o, mem_din_o, mem_wmask_o, mem_valid_o,
        input  err_o
    );

endinterface

// File: rtl/cache_mem_arbiter_wait_counter.sv
// Saturating wait-cycle counter; hit flags that LIMIT wait cycles have elapsed.
// LIMIT of 0 keeps hit low permanently.
module arb_wait_counter
    import kianv_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (LIMIT != 0) && (32'(count) == LIMIT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data.
// Single outstanding access; aborts with ERR_DATA after TIMEOUT_CYCLES wait cycles.
module cache_mem_arbiter
    import kianv_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    cache_mem_arbiter_if.slave  bus
);

    arb_state_t  state, state_nx;
    owner_t      owner, last_grant;
    logic        grant_i, grant_d;
    logic        busy, hit, err_q;
    logic        resp_i, resp_d;
    logic [31:0] i_dout_q, d_dout_q;
    logic [31:0] mem_addr_q, mem_din_q;
    logic [3:0]  mem_wmask_q;

    assign busy = (state == BUSY_I) || (state == BUSY_D);

    arb_wait_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .resetn (resetn),
        .clr    (grant_i || grant_d),
        .en     (busy && !bus.mem_ready_i),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Ties go to whichever requester did not win the previous grant.
    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_valid_i && (!bus.d_valid_i || (last_grant == OWN_D))) begin
                    grant_i  = 1'b1;
                    state_nx = BUSY_I;
                end else if (bus.d_valid_i) begin
                    grant_d  = 1'b1;
                    state_nx = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready_i || hit) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_wmask_q <= '0;
            owner       <= OWN_I;
            last_grant  <= OWN_D;
            err_q       <= 1'b0;
            i_dout_q    <= '0;
            d_dout_q    <= '0;
        end else if (grant_i) begin
            mem_addr_q  <= bus.i_addr_i;
            mem_din_q   <= '0;
            mem_wmask_q <= '0;
            owner       <= OWN_I;
            last_grant  <= OWN_I;
            err_q       <= 1'b0;
        end else if (grant_d) begin
            mem_addr_q  <= bus.d_addr_i;
            mem_din_q   <= bus.d_din_i;
            mem_wmask_q <= bus.d_wmask_i;
            owner       <= OWN_D;
            last_grant  <= OWN_D;
            err_q       <= 1'b0;
        end else if (busy) begin
            // A completion in the same cycle as the timeout is treated as normal.
            if (bus.mem_ready_i) begin
                err_q <= 1'b0;
                if (owner == OWN_I) i_dout_q <= bus.mem_dout_i;
                else                d_dout_q <= bus.mem_dout_i;
            end else if (hit) begin
                err_q <= 1'b1;
                if (owner == OWN_I) i_dout_q <= ERR_DATA;
                else                d_dout_q <= ERR_DATA;
            end
        end
    end

    always_comb begin
        resp_i          = (state == RESP) && (owner == OWN_I);
        resp_d          = (state == RESP) && (owner == OWN_D);
        bus.i_ready_o   = resp_i;
        bus.d_ready_o   = resp_d;
        bus.i_dout_o    = resp_i ? i_dout_q : '0;
        bus.d_dout_o    = resp_d ? d_dout_q : '0;
        bus.err_o       = (state == RESP) && err_q;
        bus.mem_valid_o = busy;
        bus.mem_addr_o  = mem_addr_q;
        bus.mem_din_o   = mem_din_q;
        bus.mem_wmask_o = mem_wmask_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin/timeout model.
module tb_cache_mem_arbiter;

    localparam int unsigned TO   = 8;
    localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERRD)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic last_d   = 1'b1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: who wins given the pending requests and the previous winner.
    function automatic logic pick_d(input logic iv, input logic dv);
        return dv && (!iv || !last_d);
    endfunction

    // Serves one granted access; the arbiter must be in IDLE with valids set.
    // drop: 0 keep owner valid high, 1 drop it at ready, 2 drop and scramble right after grant.
    task automatic drive_txn(input logic own_d, input int unsigned lat,
                             input logic [31:0] rdata, input int unsigned drop,
                             input string tag);
        logic [67:0] exp_req;
        logic [31:0] exp_dout;
        logic        aborted;
        logic        done;
        int unsigned w;
        exp_req = own_d ? {bus.d_addr_i, bus.d_din_i, bus.d_wmask_i}
                        : {bus.i_addr_i, 32'h0, 4'h0};
        aborted = 1'b0;
        done    = 1'b0;
        w       = 0;
        last_d  = own_d;
        tick();
        if (drop == 2) begin
            if (own_d) begin bus.d_valid_i = 1'b0; bus.d_addr_i = $urandom; bus.d_din_i = $urandom; end
            else begin bus.i_valid_i = 1'b0; bus.i_addr_i = $urandom; end
        end
        while (!done) begin
            n_checks++;
            if (bus.mem_valid_o !== 1'b1)
                $display("FAIL %s mem_valid w=%0d: got %b want 1", tag, w, bus.mem_valid_o);
            else n_pass++;
            n_checks++;
            if ({bus.mem_addr_o, bus.mem_din_o, bus.mem_wmask_o} !== exp_req)
                $display("FAIL %s mem_req w=%0d: got %h want %h", tag, w,
                         {bus.mem_addr_o, bus.mem_din_o, bus.mem_wmask_o}, exp_req);
            else n_pass++;
            n_checks++;
            if ({bus.i_ready_o, bus.d_ready_o} !== 2'b00)
                $display("FAIL %s early_ready w=%0d: got %b want 00", tag, w, {bus.i_ready_o, bus.d_ready_o});
            else n_pass++;
            if (w == lat) begin
                bus.mem_ready_i = 1'b1;
                bus.mem_dout_i  = rdata;
                tick();
                bus.mem_ready_i = 1'b0;
                bus.mem_dout_i  = $urandom;
                done = 1'b1;
            end else if (w == TO) begin
                aborted = 1'b1;
                tick();
                done = 1'b1;
            end else begin
                tick();
                w++;
            end
        end
        exp_dout = aborted ? ERRD : rdata;
        n_checks++;
        if ({bus.i_ready_o, bus.d_ready_o} !== (own_d ? 2'b01 : 2'b10))
            $display("FAIL %s ready: got %b want %b", tag, {bus.i_ready_o, bus.d_ready_o}, own_d ? 2'b01 : 2'b10);
        else n_pass++;
        n_checks++;
        if ((own_d ? bus.d_dout_o : bus.i_dout_o) !== exp_dout)
            $display("FAIL %s dout: got %h want %h", tag, own_d ? bus.d_dout_o : bus.i_dout_o, exp_dout);
        else n_pass++;
        n_checks++;
        if ((own_d ? bus.i_dout_o : bus.d_dout_o) !== 32'h0)
            $display("FAIL %s other_dout: got %h want 0", tag, own_d ? bus.i_dout_o : bus.d_dout_o);
        else n_pass++;
        n_checks++;
        if ({bus.err_o, bus.mem_valid_o} !== {aborted, 1'b0})
            $display("FAIL %s err_memvalid: got %b want %b", tag, {bus.err_o, bus.mem_valid_o}, {aborted, 1'b0});
        else n_pass++;
        if (drop == 1) begin
            if (own_d) bus.d_valid_i = 1'b0;
            else       bus.i_valid_i = 1'b0;
        end
        tick();
        n_checks++;
        if ({bus.i_ready_o, bus.d_ready_o, bus.err_o, bus.mem_valid_o} !== 4'b0000)
            $display("FAIL %s idle_after: got %b want 0000", tag,
                     {bus.i_ready_o, bus.d_ready_o, bus.err_o, bus.mem_valid_o});
        else n_pass++;
    endtask

    task automatic test_reset;
        logic [135:0] outs;
        bus.i_valid_i = 1'b1;
        bus.i_addr_i  = 32'h0000_0040;
        tick();
        outs = {bus.i_dout_o, bus.i_ready_o, bus.d_dout_o, bus.d_ready_o, bus.mem_addr_o,
                bus.mem_din_o, bus.mem_wmask_o, bus.mem_valid_o, bus.err_o};
        n_checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
        else n_pass++;
        bus.i_valid_i = 1'b0;
        resetn = 1'b1;
        tick();
        n_checks++;
        if ({bus.mem_valid_o, bus.i_ready_o, bus.d_ready_o, bus.err_o} !== 4'b0000)
            $display("FAIL reset_idle: got %b want 0000",
                     {bus.mem_valid_o, bus.i_ready_o, bus.d_ready_o, bus.err_o});
        else n_pass++;
        last_d = 1'b1;
    endtask

    task automatic test_round_robin;
        bus.i_addr_i  = 32'h0000_0100;
        bus.d_addr_i  = 32'h0000_0201;
        bus.d_din_i   = 32'h1111_2222;
        bus.d_wmask_i = 4'b1000;
        bus.i_valid_i = 1'b1;
        bus.d_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_txn(k[0], k, 32'hA000_0000 + k, 0, "round_robin");
        end
        bus.i_valid_i = 1'b0;
        bus.d_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch;
        bus.i_addr_i  = 32'h8000_0000;
        bus.i_valid_i = 1'b1;
        drive_txn(1'b0, 1, 32'h1234_5678, 1, "single_fetch");
    endtask

    task automatic test_data_write;
        bus.d_addr_i  = 32'h0000_1000;
        bus.d_din_i   = 32'hCAFE_BABE;
        bus.d_wmask_i = 4'b0011;
        bus.d_valid_i = 1'b1;
        drive_txn(1'b1, 3, 32'h0000_0000, 1, "data_write");
    endtask

    task automatic test_timeout;
        bus.d_addr_i  = 32'h0000_2000;
        bus.d_din_i   = 32'h0000_0055;
        bus.d_wmask_i = 4'b0000;
        bus.d_valid_i = 1'b1;
        drive_txn(1'b1, 20, 32'h0123_4567, 1, "timeout");
        bus.i_addr_i  = 32'h0000_3000;
        bus.i_valid_i = 1'b1;
        drive_txn(1'b0, 2, 32'hA5A5_5A5A, 1, "after_timeout");
        bus.d_valid_i = 1'b1;
        drive_txn(1'b1, TO, 32'h0BAD_F00D, 1, "timeout_coincide");
    endtask

    task automatic test_reset_mid;
        logic [135:0] outs;
        bus.i_addr_i  = 32'h0000_4000;
        bus.i_valid_i = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_valid_o !== 1'b1) $display("FAIL reset_mid_pre: got %b want 1", bus.mem_valid_o);
        else n_pass++;
        tick();
        resetn = 1'b0;
        #1;
        outs = {bus.i_dout_o, bus.i_ready_o, bus.d_dout_o, bus.d_ready_o, bus.mem_addr_o,
                bus.mem_din_o, bus.mem_wmask_o, bus.mem_valid_o, bus.err_o};
        n_checks++;
        if (outs !== '0) $display("FAIL reset_mid_outputs: got %h want 0", outs);
        else n_pass++;
        bus.i_valid_i = 1'b0;
        tick();
        resetn = 1'b1;
        last_d = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({bus.i_ready_o, bus.d_ready_o, bus.mem_valid_o} !== 3'b000)
                $display("FAIL reset_mid_no_ready: got %b want 000",
                         {bus.i_ready_o, bus.d_ready_o, bus.mem_valid_o});
            else n_pass++;
        end
        bus.i_addr_i  = 32'h0000_5000;
        bus.i_valid_i = 1'b1;
        drive_txn(1'b0, 0, 32'h7777_8888, 1, "after_reset");
    endtask

    task automatic test_random;
        logic own_d;
        for (int n = 0; n < 60; n++) begin
            if (!bus.i_valid_i && ($urandom_range(0, 2) != 0)) begin
                bus.i_valid_i = 1'b1;
                bus.i_addr_i  = $urandom & 32'hFFFF_FFFE;
            end
            if (!bus.d_valid_i && ($urandom_range(0, 2) != 0)) begin
                bus.d_valid_i = 1'b1;
                bus.d_addr_i  = $urandom | 32'h1;
                bus.d_din_i   = $urandom;
                bus.d_wmask_i = 4'($urandom_range(0, 15));
            end
            if (!bus.i_valid_i && !bus.d_valid_i) begin
                tick();
                n_checks++;
                if ({bus.mem_valid_o, bus.i_ready_o, bus.d_ready_o} !== 3'b000)
                    $display("FAIL rand_idle: got %b want 000",
                             {bus.mem_valid_o, bus.i_ready_o, bus.d_ready_o});
                else n_pass++;
            end else begin
                own_d = pick_d(bus.i_valid_i, bus.d_valid_i);
                drive_txn(own_d, $urandom_range(0, 11), $urandom, $urandom_range(1, 2), "random");
            end
        end
        bus.i_valid_i = 1'b0;
        bus.d_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        bus.i_addr_i    = '0;
        bus.i_valid_i   = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_din_i     = '0;
        bus.d_wmask_i   = '0;
        bus.d_valid_i   = 1'b0;
        bus.mem_dout_i  = '0;
        bus.mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_single_fetch();
        test_data_write();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
